wave_ctrl: RTL
==============

# wave_ctrl

Synchronous command sequencer between the SPI client and the waveform datapath (variable clock divider plus waveform memory). Takes the command byte and its strobe from the SPI client, synchronizes and decodes them, and drives the waveform selector, datapath reset pulse and run enable in a single clock domain. It also rejects illegal commands and counts them.

## Interface
- `NUM_WAVES`, default 16: number of legal waveform selectors; selector values >= NUM_WAVES are rejected.
- `RST_CYCLES`, default 2: width of the `mem_rst` pulse in `clk` cycles, legal range 1..15.
- `clk`  input  1: system clock; all state is on its rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `cmd_byte`  input  8: command from the SPI client. Bits [7:4] are the waveform selector; bits [3:0] are the opcode. Stable whenever `cmd_strobe` is high.
- `cmd_strobe`  input  1: command-valid strobe from the SPI domain; asynchronous to `clk`.
- `selector`  output  4: waveform select to the clock divider and memory.
- `mem_rst`  output  1: active-high datapath reset pulse.
- `run_en`  output  1: high when the datapath may advance; gates the divider.
- `busy`  output  1: high while the controller is in the RESET state.
- `err_cnt`  output  8: saturating count of rejected commands.

## Operation
- `cmd_strobe` passes through a 2-flop synchronizer and a rising-edge detector, producing a one-cycle `cmd_pulse`. `cmd_byte` is captured on `cmd_pulse`.
- Opcodes:
  - 4'h0 SELECT: load `selector` from [7:4], then RESET, then RUN.
  - 4'h1 PAUSE: go to PAUSED.
  - 4'h2 RESUME: PAUSED to RUN with no reset; ignored in RUN, not counted as an error.
  - 4'h3 RESTART: RESET with the current selector, then RUN.
  - Any other opcode: no state change, `err_cnt` +1.
- A SELECT with [7:4] >= NUM_WAVES is rejected: selector unchanged, `err_cnt` +1.
- States:
  - RESET: `mem_rst`=1, `run_en`=0, `busy`=1. A down-counter runs from RST_CYCLES-1; at 0 the state goes to RUN.
  - RUN: `run_en`=1.
  - PAUSED: `run_en`=0, `mem_rst`=0, selector held.
- SELECT or RESTART received in PAUSED: goes through RESET, then to RUN.
- Command received in RESET: stored in a one-deep pending slot; a later command overwrites it (last wins). The pending command executes on the first cycle after RESET completes, and is decoded like a fresh command at that point.
- Reset values: state RESET, counter RST_CYCLES-1, `selector`=0, `mem_rst`=1, `run_en`=0, `busy`=1, `err_cnt`=0, pending slot empty, synchronizer flops 0.
- On reset deassertion the controller completes a full RESET sequence, then enters RUN with selector 0.
- Assertion of `rst` mid-sequence forces reset values immediately; the pending command is discarded.

## Timing
- Let E0 be the first `clk` edge sampling `cmd_strobe`=1. Sync stage 1 captures at E0, sync stage 2 at E1, and `cmd_pulse` is registered at E2. Outputs update at E3.
- Command-to-output latency is therefore 3 cycles: `selector` and `mem_rst` change on the same edge.
- `mem_rst` stays high for exactly RST_CYCLES cycles. `run_en` rises on the same edge `mem_rst` falls.
- A strobe held high produces exactly one command. Strobes spaced closer than 2 `clk` cycles apart are not guaranteed to be distinguished.
- All outputs are registered; nothing combinational runs from input to output.
- `err_cnt` saturates at 8'hFF.

## Configuration
- `WAVE_CTRL_ERRCNT_EN` defined: `err_cnt` counts as specified above.
- `WAVE_CTRL_ERRCNT_EN` undefined: the counter is not built and `err_cnt` is tied to 8'h00. Rejection behaviour (no state change) is identical in both builds.

## Structure
- Package `wave_ctrl_pkg` holds:
  - the state enum `wave_state_e` (RESET, RUN, PAUSED);
  - opcode localparams `OP_SELECT`, `OP_PAUSE`, `OP_RESUME`, `OP_RESTART`;
  - the field-slice constants for the selector and opcode nibbles.
- One sub-module, `sync_edge`: 2-flop synchronizer plus rising-edge detect, with async active-low reset.

## Test plan
- Reset release with no commands -> `mem_rst` high for 2 cycles after release, then `run_en`=1 and `selector`=0.
- Strobe with cmd 8'h50 -> `selector`=5 and `mem_rst`=1 on E3. `mem_rst` falls and `run_en` rises on E5.
- Strobe 8'h01 (PAUSE), then 8'h02 (RESUME) -> `run_en` drops 3 cycles after the first strobe and returns with no `mem_rst` pulse; `selector` unchanged.
- Strobes 8'h07 (bad opcode), then 8'h30 with NUM_WAVES=2 (bad selector) -> no output change, `err_cnt`=2. With the macro undefined, `err_cnt`=0.
- 8'h30 strobed during RESET, then 8'h40 also during RESET -> after RESET ends, one extra RESET runs with `selector`=4; selector 3 is never driven.
- `rst` asserted mid-RESET with a command pending -> immediate reset values. After release, a boot sequence runs to `selector`=0 and the pending command is lost.

Source files
------------

// File: rtl/wave_ctrl_pkg.sv
// rtl/wave_ctrl_pkg.sv - shared types and constants for the waveform command sequencer
package wave_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } wave_state_e;

  localparam logic [3:0] OP_SELECT  = 4'h0;
  localparam logic [3:0] OP_PAUSE   = 4'h1;
  localparam logic [3:0] OP_RESUME  = 4'h2;
  localparam logic [3:0] OP_RESTART = 4'h3;

  localparam int SEL_MSB = 7;
  localparam int SEL_LSB = 4;
  localparam int OP_MSB  = 3;
  localparam int OP_LSB  = 0;

  localparam int CNT_W = 4;

endpackage

// File: rtl/wave_ctrl_sync_edge.sv
// rtl/wave_ctrl_sync_edge.sv - two-flop synchronizer with registered rising-edge pulse
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic pulse
);

  logic s1_q, s2_q, prev_q, pulse_q;
  logic s1_d, s2_d, prev_d, pulse_d;

  always_comb begin
    s1_d    = din;
    s2_d    = s1_q;
    prev_d  = s2_q;
    pulse_d = s2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  // rise leads pulse by one cycle so the command byte is latched before it is decoded
  assign rise  = s2_q & ~prev_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/wave_ctrl.sv
// rtl/wave_ctrl.sv - command sequencer driving selector, mem_rst and run_en
// Error counter is built only when WAVE_CTRL_ERRCNT_EN is defined.
module wave_ctrl
  import wave_ctrl_pkg::*;
#(
  parameter int NUM_WAVES  = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_strobe,
  output logic [3:0] selector,
  output logic       mem_rst,
  output logic       run_en,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_CYCLES - 1);
  localparam logic [4:0]       NW       = 5'(NUM_WAVES);

  logic cmd_rise, cmd_pulse;

  sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (rst),
    .din   (cmd_strobe),
    .rise  (cmd_rise),
    .pulse (cmd_pulse)
  );

  wave_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             pend_v_q, pend_v_d;
  logic [7:0]       pend_q, pend_d;
  logic             exec_v;
  logic [7:0]       exec_cmd;
  logic             err_inc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    cmd_d    = cmd_rise ? cmd_byte : cmd_q;
    exec_v   = 1'b0;
    exec_cmd = cmd_q;
    err_inc  = 1'b0;

    if (state_q == ST_RESET) begin
      if (cmd_pulse) begin
        pend_v_d = 1'b1;
        pend_d   = cmd_q;
      end
      if (cnt_q == '0) state_d = ST_RUN;
      else             cnt_d   = cnt_q - 1'b1;
    end else if (pend_v_q) begin
      // a parked command runs first; a command arriving alongside it takes the slot
      exec_v   = 1'b1;
      exec_cmd = pend_q;
      pend_v_d = cmd_pulse;
      if (cmd_pulse) pend_d = cmd_q;
    end else begin
      exec_v = cmd_pulse;
    end

    if (exec_v) begin
      case (exec_cmd[OP_MSB:OP_LSB])
        OP_SELECT: begin
          if ({1'b0, exec_cmd[SEL_MSB:SEL_LSB]} < NW) begin
            sel_d   = exec_cmd[SEL_MSB:SEL_LSB];
            state_d = ST_RESET;
            cnt_d   = CNT_INIT;
          end else begin
            err_inc = 1'b1;
          end
        end
        OP_PAUSE:   state_d = ST_PAUSED;
        OP_RESUME:  state_d = ST_RUN;
        OP_RESTART: begin
          state_d = ST_RESET;
          cnt_d   = CNT_INIT;
        end
        default:    err_inc = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RESET;
      cnt_q    <= CNT_INIT;
      sel_q    <= 4'h0;
      cmd_q    <= 8'h00;
      pend_v_q <= 1'b0;
      pend_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      cmd_q    <= cmd_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
    end
  end

  assign selector = sel_q;
  assign mem_rst  = (state_q == ST_RESET);
  assign busy     = (state_q == ST_RESET);
  assign run_en   = (state_q == ST_RUN);

`ifdef WAVE_CTRL_ERRCNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 8'h00;
    else      err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
  assign err_cnt        = 8'h00;
`endif

endmodule
